inst_fetch_arb: RTL and testbench
=================================

# inst_fetch_arb

Sequencer and arbiter that shares the single instruction ROM port between two read requesters: master 0, the CPU fetch path, and master 1, the debug/loader read path. It accepts one request at a time and drives the ROM chip-enable and word address for a configurable number of wait cycles. It then captures the instruction word and returns it to the granted master with a one-cycle valid pulse. It sits between the IF stage/debug unit and the instruction ROM.

## Interface
- WAIT_CYCLES, 1: extra ROM access cycles beyond the first; legal range 0..7.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- m0_req  in  1  master 0 request; held until m0_gnt.
- m0_addr  in  32  master 0 byte address.
- m0_gnt  out  1  master 0 grant, combinational, one cycle.
- m0_rvalid  out  1  master 0 read data valid, registered, one-cycle pulse.
- m0_rdata  out  32  master 0 instruction word.
- m1_req, m1_addr, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1.
- rom_ce  out  1  ROM chip enable; ChipEnable only during access.
- rom_addr  out  32  ROM address, with bits [1:0] forced to 0.
- rom_inst  in  32  ROM instruction output, combinational from rom_ce/rom_addr.

## Operation
- FSM has two states: IDLE and ACCESS. The encodings are the constants S_IDLE and S_ACCESS.
- **IDLE**
  - If any req is high, the arbiter picks one master and asserts its gnt in the same cycle.
  - On that edge: latch the address with bits [1:0] cleared, latch the owner id, load the counter with WAIT_CYCLES, and go to ACCESS.
  - No req: stay in IDLE with rom_ce at ChipDisable.
- **ACCESS**
  - rom_ce is ChipEnable and rom_addr is the latched address.
  - While the counter is nonzero, decrement it each cycle.
  - When the counter is 0, on that edge:
    - capture rom_inst into the owner's rdata register;
    - set the owner's rvalid for the next cycle;
    - return to IDLE.
- rdata registers hold their value until the next capture for the same master.
- Request rules:
  - A master may drop req before gnt; that request is lost, with no error.
  - After gnt, req is don't-care for that transaction.
  - A master that keeps req high after gnt issues a new request.
- Arbitration when both req are high in IDLE:
  - Without round-robin (see Configuration), master 0 always wins.
  - With round-robin, the master not granted last wins. The last-granted pointer resets to master 1, so master 0 wins first.
- At most one gnt and one rvalid are high in any cycle.
- Reset:
  - Asserting rst at any time forces IDLE and clears the counter, owner and pointer.
  - All outputs go to 0: rom_ce = ChipDisable, rom_addr = 0, gnt = 0, rvalid = 0, rdata = ZeroWord.
  - An in-flight access is dropped and no rvalid is issued.

## Timing
- Request-to-data latency:
  - Grant in cycle T (IDLE).
  - ACCESS occupies cycles T+1 .. T+1+WAIT_CYCLES.
  - rvalid and data appear in cycle T+2+WAIT_CYCLES.
- Throughput: FSM is back in IDLE in the rvalid cycle and can grant a new request there. Sustained rate is one access per WAIT_CYCLES+2 cycles.
- WAIT_CYCLES=0: ACCESS lasts one cycle; latency is 2 cycles.
- gnt depends combinationally on req and state only. It never depends on rom_inst.
- rvalid, rdata, rom_ce and rom_addr are registered or state-decoded, with no combinational path from req.

## Configuration
- INST_ARB_RR_EN
  - Defined: round-robin arbitration between the two masters, using a one-bit last-grant pointer updated on every grant.
  - Undefined: fixed priority, master 0 over master 1. The pointer is not built.

## Structure
- Constants go in defines.v: state encodings S_IDLE/S_ACCESS, WAIT counter width (3). The existing InstAddrBus, InstBus, ChipEnable, ChipDisable and ZeroWord are reused.
- One sub-module, arb_pick2, is natural.
  - Inputs: req[1:0], last pointer.
  - Outputs: one-hot grant.
  - Contains both the fixed-priority and round-robin variants under INST_ARB_RR_EN.

## Test plan
- Single fetch, WAIT_CYCLES=1, ROM word 0x100 = 0x34011100:
  - m0_req with m0_addr=0x103 at T → m0_gnt at T;
  - rom_addr=0x100 and rom_ce high during T+1..T+2;
  - m0_rvalid with m0_rdata=0x34011100 at T+3.
- Both req high continuously for 8 grants:
  - fixed priority: only m0 granted;
  - INST_ARB_RR_EN: grants alternate m0, m1, m0, m1…
- WAIT_CYCLES=0, m0_req held high: a grant every 2 cycles, and rvalid coincides with the next grant.
- m1 drops req while m0 is being served → no m1_gnt, and m1_rvalid stays 0.
- rst low in the middle of ACCESS → all outputs 0 immediately, no rvalid after release, and the next request is served normally.
- Address 0x0000_0FFC read by m1, then 0x0 by m0 → rdata registers are independent: m1_rdata keeps its word after the m0 capture.

Source files
------------

// File: rtl/inst_fetch_arb_pkg.sv
// Shared constants and types for the instruction-ROM fetch arbiter.
// Optional feature macro used by this slice: INST_ARB_RR_EN (round-robin arbitration).
package inst_fetch_arb_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;
    localparam int unsigned WAIT_W      = 3;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam inst_t ZERO_WORD = '0;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    // ROM is word-addressed; byte offset bits are dropped.
    function automatic inst_addr_t word_align(input inst_addr_t a);
        return a & ~inst_addr_t'(3);
    endfunction

endpackage

// File: rtl/inst_fetch_arb_pick2.sv
// Two-requester grant picker (arb_pick2): fixed priority, or round-robin
// when INST_ARB_RR_EN is defined. Produces a one-hot (or zero) grant.
module inst_fetch_arb_pick2 (
    input  logic [1:0] req,
`ifdef INST_ARB_RR_EN
    input  logic       last,
`endif
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
`ifdef INST_ARB_RR_EN
        // On a tie, the master not granted last time wins.
        if (req[0] && (!req[1] || last)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
`else
        if (req[0]) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/inst_fetch_arb.sv
// Shares one instruction ROM port between CPU fetch (m0) and debug/loader (m1).
// Build option: INST_ARB_RR_EN selects round-robin instead of m0-first priority.
module inst_fetch_arb
    import inst_fetch_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   m0_req,
    input  logic [INST_ADDR_W-1:0] m0_addr,
    output logic                   m0_gnt,
    output logic                   m0_rvalid,
    output logic [INST_W-1:0]      m0_rdata,
    input  logic                   m1_req,
    input  logic [INST_ADDR_W-1:0] m1_addr,
    output logic                   m1_gnt,
    output logic                   m1_rvalid,
    output logic [INST_W-1:0]      m1_rdata,
    output logic                   rom_ce,
    output logic [INST_ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0]      rom_inst
);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q;
    logic              owner_q;
    inst_addr_t        addr_q;
    logic [1:0]        pick;
    logic [1:0]        gnt;
    logic              done;

`ifdef INST_ARB_RR_EN
    logic last_q;

    inst_fetch_arb_pick2 u_pick (
        .req  ({m1_req, m0_req}),
        .last (last_q),
        .gnt  (pick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else if (|gnt) begin
            last_q <= gnt[1];
        end
    end
`else
    inst_fetch_arb_pick2 u_pick (
        .req  ({m1_req, m0_req}),
        .gnt  (pick)
    );
`endif

    always_comb begin
        state_d = state_q;
        gnt     = '0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Held reset must not leak a grant through the combinational path.
                if (rst) begin
                    gnt = pick;
                end
                if (|gnt) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign m0_gnt   = gnt[0];
    assign m1_gnt   = gnt[1];
    assign rom_ce   = (state_q == S_ACCESS) ? CHIP_ENABLE : CHIP_DISABLE;
    assign rom_addr = (state_q == S_ACCESS) ? addr_q : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (|gnt) begin
                addr_q  <= word_align(gnt[1] ? m1_addr : m0_addr);
                owner_q <= gnt[1];
                cnt_q   <= WAIT_W'(WAIT_CYCLES);
            end else if (state_q == S_ACCESS && cnt_q != '0) begin
                cnt_q <= cnt_q - WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= ZERO_WORD;
            m1_rdata  <= ZERO_WORD;
        end else begin
            m0_rvalid <= done && !owner_q;
            m1_rvalid <= done && owner_q;
            if (done && !owner_q) begin
                m0_rdata <= rom_inst;
            end
            if (done && owner_q) begin
                m1_rdata <= rom_inst;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_arb.sv
// Self-checking bench for inst_fetch_arb: two instances (WAIT_CYCLES 0 and 1),
// directed vector table, hand sequences, and randomized traffic vs a timing model.
module tb_inst_fetch_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0;
    logic        m1_req = 1'b0;
    logic [31:0] m0_addr = '0;
    logic [31:0] m1_addr = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h3401_1100;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_w
        logic        gnt0, gnt1, ce, rv0, rv1;
        logic [31:0] addr, rd0, rd1, inst;

        assign inst = rom_word(addr);

        inst_fetch_arb #(.WAIT_CYCLES(g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .m0_req    (m0_req),
            .m0_addr   (m0_addr),
            .m0_gnt    (gnt0),
            .m0_rvalid (rv0),
            .m0_rdata  (rd0),
            .m1_req    (m1_req),
            .m1_addr   (m1_addr),
            .m1_gnt    (gnt1),
            .m1_rvalid (rv1),
            .m1_rdata  (rd1),
            .rom_ce    (ce),
            .rom_addr  (addr),
            .rom_inst  (inst)
        );

        // Transaction-level model: a grant at cycle T books the port until
        // T+2+W and schedules the returned word for cycle T+2+W.
        int          t = 0;
        int          free_at = 0;
        int          pend_at = -1;
        bit          pend_own = 1'b0;
        bit          last = 1'b1;
        logic [31:0] pend_data = '0;
        logic [31:0] acc_addr = '0;
        logic [31:0] md0 = '0;
        logic [31:0] md1 = '0;

        always @(negedge clk) begin : model
            bit e_g0, e_g1, e_ce, e_v0, e_v1, win;
            e_g0 = 1'b0; e_g1 = 1'b0; e_ce = 1'b0; e_v0 = 1'b0; e_v1 = 1'b0; win = 1'b0;
            if (!rst) begin
                free_at = t + 1;
                pend_at = -1;
                last    = 1'b1;
                md0     = '0;
                md1     = '0;
            end else begin
                if (pend_at == t) begin
                    if (pend_own) begin e_v1 = 1'b1; md1 = pend_data; end
                    else          begin e_v0 = 1'b1; md0 = pend_data; end
                end
                if (t < free_at) begin
                    e_ce = 1'b1;
                end else if (m0_req || m1_req) begin
`ifdef INST_ARB_RR_EN
                    win = (m0_req && m1_req) ? !last : m1_req;
`else
                    win = !m0_req;
`endif
                    e_g0      = !win;
                    e_g1      = win;
                    last      = win;
                    acc_addr  = (win ? m1_addr : m0_addr) & 32'hFFFF_FFFC;
                    free_at   = t + 2 + g;
                    pend_at   = free_at;
                    pend_own  = win;
                    pend_data = rom_word(acc_addr);
                end
            end
            check($sformatf("w%0d c%0d gnt0", g, t), 32'(gnt0), 32'(e_g0));
            check($sformatf("w%0d c%0d gnt1", g, t), 32'(gnt1), 32'(e_g1));
            check($sformatf("w%0d c%0d ce", g, t), 32'(ce), 32'(e_ce));
            if (e_ce) check($sformatf("w%0d c%0d rom_addr", g, t), addr, acc_addr);
            check($sformatf("w%0d c%0d rv0", g, t), 32'(rv0), 32'(e_v0));
            check($sformatf("w%0d c%0d rv1", g, t), 32'(rv1), 32'(e_v1));
            check($sformatf("w%0d c%0d rdata0", g, t), rd0, md0);
            check($sformatf("w%0d c%0d rdata1", g, t), rd1, md1);
            t++;
        end
    end

    typedef struct {
        bit          rst, r0;
        logic [31:0] a0;
        bit          r1;
        logic [31:0] a1;
        bit          g0, g1, ce;
        logic [31:0] addr;
        bit          v0, v1;
        logic [31:0] d0, d1;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int          ng0, ng1, nco;
        logic [7:0]  seq;
        logic [7:0]  exp_seq;
        // Expected values for the WAIT_CYCLES=1 instance.
        tbl[0]  = '{1, 1, 32'h103, 0, 0,      1, 0, 0, 0,      0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 1, 32'hFFC,      0, 0, 1, 32'h100, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0,            0, 0, 1, 32'h100, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 0,            0, 0, 0, 0,      1, 0, 32'h34011100, 0};
        tbl[4]  = '{1, 0, 0, 1, 32'hFFC,      0, 1, 0, 0,      0, 0, 32'h34011100, 0};
        tbl[5]  = '{1, 1, 0, 0, 0,            0, 0, 1, 32'hFFC, 0, 0, 32'h34011100, 0};
        tbl[6]  = '{1, 1, 0, 0, 0,            0, 0, 1, 32'hFFC, 0, 0, 32'h34011100, 0};
        tbl[7]  = '{1, 1, 0, 0, 0,            1, 0, 0, 0,      0, 1, 32'h34011100, 32'h0FFCF003};
        tbl[8]  = '{1, 0, 0, 0, 0,            0, 0, 1, 0,      0, 0, 32'h34011100, 32'h0FFCF003};
        tbl[9]  = '{1, 0, 0, 0, 0,            0, 0, 1, 0,      0, 0, 32'h34011100, 32'h0FFCF003};
        tbl[10] = '{1, 0, 0, 0, 0,            0, 0, 0, 0,      1, 0, 32'h0000FFFF, 32'h0FFCF003};
        tbl[11] = '{1, 1, 32'h100, 0, 0,      1, 0, 0, 0,      0, 0, 32'h0000FFFF, 32'h0FFCF003};
        tbl[12] = '{1, 0, 0, 0, 0,            0, 0, 1, 32'h100, 0, 0, 32'h0000FFFF, 32'h0FFCF003};
        tbl[13] = '{0, 0, 0, 0, 0,            0, 0, 0, 0,      0, 0, 0, 0};
        tbl[14] = '{1, 0, 0, 0, 0,            0, 0, 0, 0,      0, 0, 0, 0};
        tbl[15] = '{1, 0, 0, 0, 0,            0, 0, 0, 0,      0, 0, 0, 0};
        tbl[16] = '{1, 0, 0, 1, 32'h100,      0, 1, 0, 0,      0, 0, 0, 0};
        tbl[17] = '{1, 0, 0, 0, 0,            0, 0, 1, 32'h100, 0, 0, 0, 0};
        tbl[18] = '{1, 0, 0, 0, 0,            0, 0, 1, 32'h100, 0, 0, 0, 0};
        tbl[19] = '{1, 0, 0, 0, 0,            0, 0, 0, 0,      0, 1, 0, 32'h34011100};

        repeat (3) @(negedge clk);
        check("reset ce", 32'(g_w[1].ce), 32'd0);
        check("reset rdata0", g_w[1].rd0, 32'd0);

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            rst = tbl[i].rst; m0_req = tbl[i].r0; m0_addr = tbl[i].a0;
            m1_req = tbl[i].r1; m1_addr = tbl[i].a1;
            @(negedge clk);
            check($sformatf("vec%0d gnt0", i), 32'(g_w[1].gnt0), 32'(tbl[i].g0));
            check($sformatf("vec%0d gnt1", i), 32'(g_w[1].gnt1), 32'(tbl[i].g1));
            check($sformatf("vec%0d ce", i), 32'(g_w[1].ce), 32'(tbl[i].ce));
            if (tbl[i].ce) check($sformatf("vec%0d rom_addr", i), g_w[1].addr, tbl[i].addr);
            check($sformatf("vec%0d rv0", i), 32'(g_w[1].rv0), 32'(tbl[i].v0));
            check($sformatf("vec%0d rv1", i), 32'(g_w[1].rv1), 32'(tbl[i].v1));
            check($sformatf("vec%0d rdata0", i), g_w[1].rd0, tbl[i].d0);
            check($sformatf("vec%0d rdata1", i), g_w[1].rd1, tbl[i].d1);
        end

        // Both masters requesting continuously: eight grants on the W=1 instance.
        seq = '0; ng0 = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            m0_req = 1'b1; m0_addr = 32'h200 + 32'(c);
            m1_req = 1'b1; m1_addr = 32'h400 + 32'(c);
            @(negedge clk);
            if (g_w[1].gnt0 || g_w[1].gnt1) begin
                seq = {seq[6:0], g_w[1].gnt1};
                ng0++;
            end
        end
`ifdef INST_ARB_RR_EN
        exp_seq = 8'b0101_0101;
`else
        exp_seq = 8'b0000_0000;
`endif
        check("both-req grant count", 32'(ng0), 32'd8);
        check("both-req grant order", 32'(seq), 32'(exp_seq));

        // WAIT_CYCLES=0 back-to-back: grant every 2 cycles, rvalid on the next grant.
        @(posedge clk); #1; m0_req = 1'b0; m1_req = 1'b0;
        repeat (4) @(posedge clk);
        ng0 = 0; ng1 = 0; nco = 0;
        for (int c = 0; c < 10; c++) begin
            #1; m0_req = 1'b1; m0_addr = 32'h800 + 32'(4 * c);
            @(negedge clk);
            if (g_w[0].gnt0) ng0++;
            if (g_w[0].rv0) ng1++;
            if (g_w[0].gnt0 && g_w[0].rv0) nco++;
            @(posedge clk);
        end
        check("w0 b2b grants", 32'(ng0), 32'd5);
        check("w0 b2b rvalid", 32'(ng1), 32'd4);
        check("w0 b2b rvalid with grant", 32'(nco), 32'd4);

        for (int c = 0; c < 600; c++) begin
            #1;
            rst     = ($urandom_range(0, 63) != 0);
            m0_req  = ($urandom_range(0, 3) != 0);
            m1_req  = ($urandom_range(0, 2) != 0);
            m0_addr = ($urandom_range(0, 3) == 0) ? 32'h100 : $urandom;
            m1_addr = $urandom;
            @(posedge clk);
        end
        #1; rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
